// File: rtl/jesd204_cfg_axil_slave_if.sv
// AXI4-Lite bundle between the interconnect (master) and the JESD204 RX
// configuration register file (slave).
interface jesd204_cfg_axil_slave_if;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/jesd204_cfg_axil_slave.sv
// AXI4-Lite register file for the JESD204 RX core: static link configuration,
// a software RX-reset pulse generator and sticky per-lane error flags.
module jesd204_cfg_axil_slave #(
  parameter int unsigned F_val         = 4,
  parameter int unsigned K_val         = 16,
  parameter bit          scrambler_en  = 1'b0,
  parameter logic [7:0]  active_lanes  = 8'b00000001,
  parameter int unsigned jesd_subclass = 1,
  parameter int unsigned PULSE_LEN     = 4800,
  parameter logic [31:0] VERSION       = 32'h0001_0000
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  jesd204_cfg_axil_slave_if.slave        s_axi,
  output logic [7:0]                     cfg_f_m1,
  output logic [4:0]                     cfg_k_m1,
  output logic                           cfg_scr_en,
  output logic [1:0]                     cfg_subclass,
  output logic [7:0]                     cfg_lanes,
  input  logic [7:0]                     lane_err,
  output logic                           reset_rx_jesd
);

  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  localparam logic [7:0]       F_RST    = 8'(F_val - 1);
  localparam logic [4:0]       K_RST    = 5'(K_val - 1);
  localparam logic [1:0]       SUB_RST  = 2'(jesd_subclass);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);

  localparam logic [9:0] A_VERSION  = 10'd0;
  localparam logic [9:0] A_RST_CTRL = 10'd1;
  localparam logic [9:0] A_FRAME    = 10'd2;
  localparam logic [9:0] A_MODE     = 10'd3;
  localparam logic [9:0] A_LANES    = 10'd4;
  localparam logic [9:0] A_ERR      = 10'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t          w_state, w_state_nxt;
  r_state_t          r_state, r_state_nxt;
  logic              w_fire, r_fire;
  logic              bvalid_c, rvalid_c;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q, rd_data;
  logic [9:0]        wr_idx, rd_idx;
  logic              wr_hit, rd_hit;
  logic [7:0]        err_flags, err_clr;
  logic              pulse_start;
  logic [CNT_W-1:0]  pulse_cnt;
  logic              unused_bits;

  assign wr_idx = s_axi.awaddr[11:2];
  assign rd_idx = s_axi.araddr[11:2];
  assign wr_hit = (wr_idx <= A_ERR);
  assign rd_hit = (rd_idx <= A_ERR);

  assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0],
                         s_axi.wdata[31:13], s_axi.wstrb[3:2]};

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  // AW and W are only taken together, and never while a response is pending.
  always_comb begin
    w_state_nxt = w_state;
    w_fire      = 1'b0;
    bvalid_c    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s_axi.awvalid && s_axi.wvalid) begin
          w_fire      = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid_c = 1'b1;
        if (s_axi.bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    r_fire      = 1'b0;
    rvalid_c    = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s_axi.arvalid) begin
          r_fire      = 1'b1;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        rvalid_c = 1'b1;
        if (s_axi.rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign s_axi.awready = w_fire;
  assign s_axi.wready  = w_fire;
  assign s_axi.bvalid  = bvalid_c;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = r_fire;
  assign s_axi.rvalid  = rvalid_c;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign err_clr     = (w_fire && wr_idx == A_ERR && s_axi.wstrb[0]) ? s_axi.wdata[7:0] : 8'h00;
  assign pulse_start = w_fire && wr_idx == A_RST_CTRL && s_axi.wstrb[0] && s_axi.wdata[0];

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      bresp_q      <= RESP_OKAY;
      cfg_f_m1     <= F_RST;
      cfg_k_m1     <= K_RST;
      cfg_scr_en   <= scrambler_en;
      cfg_subclass <= SUB_RST;
      cfg_lanes    <= active_lanes;
    end else if (w_fire) begin
      bresp_q <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      case (wr_idx)
        A_FRAME: begin
          if (s_axi.wstrb[0]) cfg_f_m1 <= s_axi.wdata[7:0];
          if (s_axi.wstrb[1]) cfg_k_m1 <= s_axi.wdata[12:8];
        end
        A_MODE: begin
          if (s_axi.wstrb[0]) cfg_scr_en   <= s_axi.wdata[0];
          if (s_axi.wstrb[1]) cfg_subclass <= s_axi.wdata[9:8];
        end
        A_LANES: begin
          if (s_axi.wstrb[0]) cfg_lanes <= s_axi.wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // New lane errors are ORed in after the clear so a coincident set wins.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      err_flags <= 8'h00;
    end else begin
      err_flags <= (err_flags & ~err_clr) | lane_err;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      pulse_cnt <= '0;
    end else if (pulse_start) begin
      pulse_cnt <= CNT_LOAD;
    end else if (pulse_cnt != '0) begin
      pulse_cnt <= pulse_cnt - CNT_W'(1);
    end
  end

  assign reset_rx_jesd = (pulse_cnt != '0);

  always_comb begin
    rd_data = 32'h0;
    case (rd_idx)
      A_VERSION:  rd_data = VERSION;
      A_RST_CTRL: rd_data[0] = reset_rx_jesd;
      A_FRAME:    rd_data[12:0] = {cfg_k_m1, cfg_f_m1};
      A_MODE: begin
        rd_data[9:8] = cfg_subclass;
        rd_data[0]   = cfg_scr_en;
      end
      A_LANES:    rd_data[7:0] = cfg_lanes;
      A_ERR:      rd_data[7:0] = err_flags;
      default:    rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      rdata_q <= 32'h0;
      rresp_q <= RESP_OKAY;
    end else if (r_fire) begin
      rdata_q <= rd_data;
      rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_jesd204_cfg_axil_slave.sv
// Directed plus randomized bench for jesd204_cfg_axil_slave, checked against a
// register-level model of the configuration map kept in plain variables.
module tb_jesd204_cfg_axil_slave;

  localparam int          PULSE_LEN = 4800;
  localparam logic [31:0] VERSION   = 32'h0001_0000;

  logic       s_axi_aclk = 1'b0;
  logic       s_axi_aresetn;
  logic [7:0] cfg_f_m1;
  logic [4:0] cfg_k_m1;
  logic       cfg_scr_en;
  logic [1:0] cfg_subclass;
  logic [7:0] cfg_lanes;
  logic [7:0] lane_err;
  logic       reset_rx_jesd;

  jesd204_cfg_axil_slave_if axi ();

  jesd204_cfg_axil_slave #(
    .F_val(4), .K_val(16), .scrambler_en(1'b0), .active_lanes(8'h01),
    .jesd_subclass(1), .PULSE_LEN(PULSE_LEN), .VERSION(VERSION)
  ) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .s_axi         (axi),
    .cfg_f_m1      (cfg_f_m1),
    .cfg_k_m1      (cfg_k_m1),
    .cfg_scr_en    (cfg_scr_en),
    .cfg_subclass  (cfg_subclass),
    .cfg_lanes     (cfg_lanes),
    .lane_err      (lane_err),
    .reset_rx_jesd (reset_rx_jesd)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int cyc = 0;
  always @(posedge s_axi_aclk) cyc <= cyc + 1;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: architectural register contents plus pulse start time
  logic [7:0] mF, mLanes, mErr;
  logic [4:0] mK;
  logic       mScr;
  logic [1:0] mSub;
  bit         pulseValid;
  int         pulseStart;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mF = 8'd3; mK = 5'd15; mScr = 1'b0; mSub = 2'd1; mLanes = 8'h01; mErr = 8'h00;
    pulseValid = 1'b0; pulseStart = 0;
  endtask

  function automatic bit pulseActive(input int c);
    return pulseValid && (c >= pulseStart) && (c < pulseStart + PULSE_LEN);
  endfunction

  function automatic logic [31:0] modelRead(input logic [11:0] addr, input int c);
    case (addr[11:2])
      10'd0:   return VERSION;
      10'd1:   return 32'(pulseActive(c));
      10'd2:   return 32'(mK) * 256 + 32'(mF);
      10'd3:   return 32'(mSub) * 256 + 32'(mScr);
      10'd4:   return 32'(mLanes);
      10'd5:   return 32'(mErr);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [1:0] modelResp(input logic [11:0] addr);
    return (addr[11:2] <= 10'd5) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] modelCfg();
    return 32'({mK, mF, mLanes, mSub, mScr});
  endfunction

  function automatic logic [31:0] dutCfg();
    return 32'({cfg_k_m1, cfg_f_m1, cfg_lanes, cfg_subclass, cfg_scr_en});
  endfunction

  task automatic modelWrite(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [7:0] lane, input int hs);
    logic [7:0] clr;
    clr = 8'h00;
    case (addr[11:2])
      10'd1: if (strb[0] && data[0]) begin pulseValid = 1'b1; pulseStart = hs; end
      10'd2: begin if (strb[0]) mF = data[7:0]; if (strb[1]) mK = data[12:8]; end
      10'd3: begin if (strb[0]) mScr = data[0]; if (strb[1]) mSub = data[9:8]; end
      10'd4: if (strb[0]) mLanes = data[7:0];
      10'd5: if (strb[0]) clr = data[7:0];
      default: ;
    endcase
    mErr = (mErr & ~clr) | lane;
  endtask

  task automatic axiWrite(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [7:0] lane, output logic [1:0] resp, output int hs);
    int n;
    @(negedge s_axi_aclk);
    axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0; lane_err = lane;
    #1;
    n = 0;
    while (!(axi.awready && axi.wready) && n < 50) begin @(negedge s_axi_aclk); #1; n++; end
    checkOutput("aw_w_accept", 32'(axi.awready && axi.wready), 32'd1);
    @(posedge s_axi_aclk); #1;
    hs = cyc;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; lane_err = 8'h00;
    modelWrite(addr, data, strb, lane, hs);
    checkOutput("rst_pulse_hs", 32'(reset_rx_jesd), 32'(pulseActive(hs)));
    n = 0;
    while (!axi.bvalid && n < 50) begin @(negedge s_axi_aclk); n++; end
    checkOutput("bvalid", 32'(axi.bvalid), 32'd1);
    resp = axi.bresp;
    axi.bready = 1'b1;
    @(posedge s_axi_aclk); #1;
    axi.bready = 1'b0;
  endtask

  task automatic axiRead(input logic [11:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int arCyc);
    int n;
    @(negedge s_axi_aclk);
    axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b0;
    #1;
    n = 0;
    while (!axi.arready && n < 50) begin @(negedge s_axi_aclk); #1; n++; end
    checkOutput("ar_accept", 32'(axi.arready), 32'd1);
    @(posedge s_axi_aclk); #1;
    arCyc = cyc;
    axi.arvalid = 1'b0;
    n = 0;
    while (!axi.rvalid && n < 50) begin @(negedge s_axi_aclk); n++; end
    checkOutput("rvalid", 32'(axi.rvalid), 32'd1);
    data = axi.rdata; resp = axi.rresp;
    axi.rready = 1'b1;
    @(posedge s_axi_aclk); #1;
    axi.rready = 1'b0;
  endtask

  task automatic writeCheck(input string tag, input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [7:0] lane, output int hs);
    logic [1:0] resp;
    axiWrite(addr, data, strb, lane, resp, hs);
    checkOutput({tag, "_bresp"}, 32'(resp), 32'(modelResp(addr)));
    checkOutput({tag, "_cfg"}, dutCfg(), modelCfg());
    checkOutput({tag, "_rst"}, 32'(reset_rx_jesd), 32'(pulseActive(cyc)));
  endtask

  task automatic readCheck(input string tag, input logic [11:0] addr);
    logic [31:0] data;
    logic [1:0]  resp;
    int          arCyc;
    axiRead(addr, data, resp, arCyc);
    checkOutput({tag, "_rdata"}, data, modelRead(addr, arCyc - 1));
    checkOutput({tag, "_rresp"}, 32'(resp), 32'(modelResp(addr)));
  endtask

  task automatic pulseLane(input logic [7:0] v);
    @(negedge s_axi_aclk); lane_err = v;
    @(negedge s_axi_aclk); lane_err = 8'h00;
    mErr = mErr | v;
  endtask

  task automatic waitPulseFall(output int fall);
    int n;
    n = 0;
    while (reset_rx_jesd && n < 12000) begin @(posedge s_axi_aclk); #1; n++; end
    fall = cyc;
  endtask

  task automatic applyStimulus();
    logic [11:0] addr;
    logic [7:0]  lane;
    int          hs;
    if ($urandom_range(0, 4) == 0) addr = 12'($urandom_range(6, 1023) * 4);
    else                           addr = 12'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
    lane = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    if ($urandom_range(0, 1) == 1) writeCheck("rand_wr", addr, $urandom, 4'($urandom), lane, hs);
    else                           readCheck("rand_rd", addr);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h1, h2, fall, arCyc;
    logic [31:0] exp;

    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    lane_err = 8'h00;
    s_axi_aresetn = 1'b0;
    modelReset();

    repeat (3) @(posedge s_axi_aclk);
    #1;
    checkOutput("reset_handshake", 32'({axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid}), 32'd0);
    checkOutput("reset_data", 32'(axi.rdata) ^ 32'(axi.rresp) ^ 32'(axi.bresp), 32'd0);
    checkOutput("reset_cfg", dutCfg(), modelCfg());
    checkOutput("reset_pulse", 32'(reset_rx_jesd), 32'd0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;

    $display("[TB] T1 reset values");
    readCheck("t1_version", 12'h000);
    readCheck("t1_frame", 12'h008);
    readCheck("t1_mode", 12'h00C);
    readCheck("t1_lanes", 12'h010);
    readCheck("t1_err", 12'h014);

    $display("[TB] T2 byte strobes");
    writeCheck("t2_partial", 12'h008, 32'h0000_1F07, 4'b0001, 8'h00, h1);
    readCheck("t2_frame_partial", 12'h008);
    writeCheck("t2_full", 12'h008, 32'h0000_1F07, 4'b1111, 8'h00, h1);
    checkOutput("t2_f_m1", 32'(cfg_f_m1), 32'd7);
    checkOutput("t2_k_m1", 32'(cfg_k_m1), 32'd31);
    writeCheck("t2_mode", 12'h00E, 32'hFFFF_FF01, 4'b0011, 8'h00, h1);
    readCheck("t2_mode_rd", 12'h00C);
    writeCheck("t2_version_ro", 12'h000, 32'hDEAD_BEEF, 4'hF, 8'h00, h1);
    readCheck("t2_version_rd", 12'h000);

    $display("[TB] T3 software reset pulse");
    checkOutput("t3_idle", 32'(reset_rx_jesd), 32'd0);
    writeCheck("t3_start", 12'h004, 32'h1, 4'b0001, 8'h00, h1);
    readCheck("t3_rst_rd", 12'h004);
    waitPulseFall(fall);
    checkOutput("t3_pulse_len", 32'(fall - h1), 32'(PULSE_LEN));
    writeCheck("t3_start2", 12'h004, 32'h1, 4'b0001, 8'h00, h1);
    writeCheck("t3_write0", 12'h004, 32'hFFFF_FFFE, 4'hF, 8'h00, h2);
    while (cyc < h1 + 99) begin @(posedge s_axi_aclk); #1; end
    writeCheck("t3_restart", 12'h004, 32'h1, 4'b0001, 8'h00, h2);
    waitPulseFall(fall);
    checkOutput("t3_restart_len", 32'(fall - h1), 32'(h2 - h1 + PULSE_LEN));
    checkOutput("t3_restart_total", 32'(fall - h1), 32'd4900);

    $display("[TB] T4 sticky lane errors");
    pulseLane(8'h05);
    readCheck("t4_err", 12'h014);
    writeCheck("t4_clr_vs_set", 12'h014, 32'h01, 4'b0001, 8'h01, h1);
    readCheck("t4_err_set_wins", 12'h014);
    writeCheck("t4_clr_nostrb", 12'h014, 32'h05, 4'b0010, 8'h00, h1);
    readCheck("t4_err_kept", 12'h014);
    writeCheck("t4_clr_all", 12'h014, 32'h05, 4'b0001, 8'h00, h1);
    readCheck("t4_err_zero", 12'h014);

    $display("[TB] T5 response backpressure");
    @(negedge s_axi_aclk);
    axi.awaddr = 12'h010; axi.wdata = 32'hA5; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    @(posedge s_axi_aclk); #1;
    modelWrite(12'h010, 32'hA5, 4'hF, 8'h00, cyc);
    axi.wdata = 32'h3C;
    for (int i = 0; i < 10; i++) begin
      @(negedge s_axi_aclk);
      checkOutput("t5_bvalid_hold", 32'(axi.bvalid), 32'd1);
      checkOutput("t5_awready_blocked", 32'(axi.awready), 32'd0);
    end
    checkOutput("t5_lanes_first", 32'(cfg_lanes), 32'(mLanes));
    axi.bready = 1'b1;
    @(posedge s_axi_aclk); #1;
    axi.bready = 1'b0;
    checkOutput("t5_pending_accept", 32'(axi.awready), 32'd1);
    @(posedge s_axi_aclk); #1;
    modelWrite(12'h010, 32'h3C, 4'hF, 8'h00, cyc);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checkOutput("t5_bvalid2", 32'(axi.bvalid), 32'd1);
    axi.bready = 1'b1;
    @(posedge s_axi_aclk); #1;
    axi.bready = 1'b0;
    checkOutput("t5_lanes_second", 32'(cfg_lanes), 32'(mLanes));

    @(negedge s_axi_aclk);
    axi.araddr = 12'h010; axi.arvalid = 1'b1; axi.rready = 1'b0;
    @(posedge s_axi_aclk); #1;
    arCyc = cyc;
    exp = modelRead(12'h010, arCyc - 1);
    axi.araddr = 12'h000;
    for (int i = 0; i < 10; i++) begin
      @(negedge s_axi_aclk);
      checkOutput("t5_rvalid_hold", 32'(axi.rvalid), 32'd1);
      checkOutput("t5_arready_blocked", 32'(axi.arready), 32'd0);
      checkOutput("t5_rdata_hold", axi.rdata, exp);
    end
    axi.rready = 1'b1;
    @(posedge s_axi_aclk); #1;
    axi.rready = 1'b0;
    checkOutput("t5_pending_ar", 32'(axi.arready), 32'd1);
    @(posedge s_axi_aclk); #1;
    axi.arvalid = 1'b0;
    checkOutput("t5_rvalid2", 32'(axi.rvalid), 32'd1);
    checkOutput("t5_rdata2", axi.rdata, modelRead(12'h000, cyc - 1));
    axi.rready = 1'b1;
    @(posedge s_axi_aclk); #1;
    axi.rready = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 60; i++) applyStimulus();

    $display("[TB] T6 unmapped access and async reset");
    writeCheck("t6_unmapped_wr", 12'h100, 32'hFFFF_FFFF, 4'hF, 8'h00, h1);
    readCheck("t6_unmapped_rd", 12'h100);
    @(negedge s_axi_aclk);
    axi.awaddr = 12'h008; axi.wdata = 32'h0000_1234; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    @(posedge s_axi_aclk); #1;
    modelWrite(12'h008, 32'h0000_1234, 4'hF, 8'h00, cyc);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checkOutput("t6_bvalid_before", 32'(axi.bvalid), 32'd1);
    checkOutput("t6_cfg_before", dutCfg(), modelCfg());
    #2;
    s_axi_aresetn = 1'b0;
    modelReset();
    #1;
    checkOutput("t6_bvalid_async", 32'(axi.bvalid), 32'd0);
    checkOutput("t6_cfg_async", dutCfg(), modelCfg());
    checkOutput("t6_pulse_async", 32'(reset_rx_jesd), 32'd0);
    repeat (2) @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    readCheck("t6_frame_after", 12'h008);
    readCheck("t6_err_after", 12'h014);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
